cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_pkg.sv | 38 +++
 rtl/cdb_arbiter_if.sv | 11 +
 rtl/cdb_arbiter_rr_pick.sv | 40 ++++
 rtl/cdb_arbiter.sv | 71 +++++++
 tb/tb_cdb_arbiter.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/cdb_arbiter_pkg.sv
// sys_defs: shared FU layout, CDB width and helpers for the completion arbiter
`ifndef N
`define N 2
`endif
`ifndef LOAD_BUFFER_SZ
`define LOAD_BUFFER_SZ 2
`endif
`ifndef NUM_FU_MULT
`define NUM_FU_MULT 2
`endif
`ifndef NUM_FU_ALU
`define NUM_FU_ALU 2
`endif
`ifndef NUM_FU_BRANCH
`define NUM_FU_BRANCH 1
`endif
`ifndef NUM_FU_TOTAL
`define NUM_FU_TOTAL (`LOAD_BUFFER_SZ + `NUM_FU_MULT + `NUM_FU_ALU + `NUM_FU_BRANCH)
`endif
package sys_defs;
   localparam int N = `N;
   localparam int NUM_FU_TOTAL = `NUM_FU_TOTAL;
   localparam int LOAD_BASE = 0;
   localparam int MULT_BASE = LOAD_BASE + `LOAD_BUFFER_SZ;
   localparam int ALU_BASE = MULT_BASE + `NUM_FU_MULT;
   localparam int BRANCH_BASE = ALU_BASE + `NUM_FU_ALU;
   localparam int LANE_W = $clog2(N + 1);
   localparam int PTR_W = $clog2(NUM_FU_TOTAL);
   typedef logic [NUM_FU_TOTAL-1:0] fu_vec_t;
   // ALU and branch units are single-cycle and cannot hold a result, so they never stall
   localparam fu_vec_t FIXED_FU_MASK = fu_vec_t'(((1 << (`NUM_FU_ALU + `NUM_FU_BRANCH)) - 1) << ALU_BASE);
   function automatic int popcount(input fu_vec_t v);
      int c;
      c = 0;
      for (int i = 0; i < NUM_FU_TOTAL; i++) c += int'(v[i]);
      return c;
   endfunction
endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: FU request / CDB lane grant bundle between FUs and the arbiter
interface cdb_arbiter_if import sys_defs::*; ();
   fu_vec_t fu_req;
   logic [N-1:0][NUM_FU_TOTAL-1:0] complete_gnt_bus;
   fu_vec_t fu_gnt;
   logic [LANE_W-1:0] lanes_used;
   logic starve_active;
   logic fixed_overflow;
   modport master (input fu_req, output complete_gnt_bus, fu_gnt, lanes_used, starve_active, fixed_overflow);
   modport slave (output fu_req, input complete_gnt_bus, fu_gnt, lanes_used, starve_active, fixed_overflow);
endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// rr_pick: up to min(K, lim) one-hot picks from req, scanning from ptr with wraparound
module rr_pick #(
   parameter int W = 8,
   parameter int K = 2,
   localparam int PW = $clog2(W),
   localparam int CW = $clog2(K + 1)
) (
   input logic [W-1:0] req,
   input logic [PW-1:0] ptr,
   input logic [CW-1:0] lim,
   output logic [K-1:0][W-1:0] pick,
   output logic [CW-1:0] cnt,
   output logic [PW-1:0] nxt
);
   logic [W-1:0] rot;
   logic [K-1:0][W-1:0] rpick;
   logic [2*W-1:0] dbl;
   logic [PW:0] sum;
   // work in the rotated domain (bit i = req[ptr+i]) so the scan is a plain priority loop
   always_comb begin
      rot = W'({req, req} >> ptr);
      rpick = '0;
      cnt = '0;
      nxt = ptr;
      sum = '0;
      dbl = '0;
      pick = '0;
      for (int i = 0; i < W; i++)
         if (rot[i] && cnt < lim && cnt < CW'(K)) begin
            for (int k = 0; k < K; k++) if (cnt == CW'(k)) rpick[k][i] = 1'b1;
            cnt = cnt + CW'(1);
            sum = {1'b0, ptr} + (PW + 1)'(i + 1);
            nxt = PW'(sum >= (PW + 1)'(W) ? sum - (PW + 1)'(W) : sum);
         end
      for (int k = 0; k < K; k++) begin
         dbl = {rpick[k], rpick[k]} << ptr;
         pick[k] = dbl[2*W-1:W];
      end
   end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: packs FU results onto N CDB lanes; fixed FUs first, then starved, then round-robin
module cdb_arbiter import sys_defs::*; #(
   parameter int STARVE_LIMIT = 4
) (
   input logic clock,
   input logic reset,
   cdb_arbiter_if.master bus
);
   localparam int AW = $clog2(STARVE_LIMIT + 1);
   logic [PTR_W-1:0] rr_ptr, rr_nxt;
   logic [AW-1:0] age [NUM_FU_TOTAL];
   logic fixed_overflow;
   fu_vec_t req, fixed, aged, starved, rest, gnt, ph;
   logic [N-1:0][NUM_FU_TOTAL-1:0] lane_ab, lane, pick;
   logic [LANE_W-1:0] used_ab, lim, cnt_c;
   assign req = bus.fu_req;
   assign fixed = req & FIXED_FU_MASK;
   always_comb begin
      aged = '0;
      for (int i = 0; i < NUM_FU_TOTAL; i++) aged[i] = ~FIXED_FU_MASK[i] & (age[i] >= AW'(STARVE_LIMIT));
   end
   assign starved = req & aged;
   assign rest = req & ~FIXED_FU_MASK & ~starved;
   // pass 0 packs fixed requests, pass 1 packs starved ones behind them
   always_comb begin
      lane_ab = '0;
      used_ab = '0;
      ph = '0;
      for (int p = 0; p < 2; p++) begin
         ph = p == 0 ? fixed : starved;
         for (int i = 0; i < NUM_FU_TOTAL; i++)
            if (ph[i] && used_ab < LANE_W'(N)) begin
               for (int k = 0; k < N; k++) if (used_ab == LANE_W'(k)) lane_ab[k][i] = 1'b1;
               used_ab = used_ab + LANE_W'(1);
            end
      end
   end
   assign lim = LANE_W'(N) - used_ab;
   rr_pick #(.W(NUM_FU_TOTAL), .K(N)) u_pick (
      .req(rest),
      .ptr(rr_ptr),
      .lim(lim),
      .pick(pick),
      .cnt(cnt_c),
      .nxt(rr_nxt)
   );
   always_comb begin
      lane = lane_ab;
      gnt = '0;
      for (int k = 0; k < N; k++)
         for (int j = 0; j < N; j++)
            if (int'(used_ab) + j == k) lane[k] = lane[k] | pick[j];
      for (int k = 0; k < N; k++) gnt = gnt | lane[k];
   end
   assign bus.complete_gnt_bus = reset ? '0 : lane;
   assign bus.fu_gnt = reset ? '0 : gnt;
   assign bus.lanes_used = reset ? '0 : used_ab + cnt_c;
   assign bus.starve_active = ~reset & (|aged);
   assign bus.fixed_overflow = fixed_overflow;
   always_ff @(posedge clock)
      if (reset) begin
         rr_ptr <= '0;
         fixed_overflow <= 1'b0;
         for (int i = 0; i < NUM_FU_TOTAL; i++) age[i] <= '0;
      end else begin
         rr_ptr <= rr_nxt;
         fixed_overflow <= fixed_overflow | (popcount(fixed) > N);
         for (int i = 0; i < NUM_FU_TOTAL; i++)
            age[i] <= (req[i] && !gnt[i] && !FIXED_FU_MASK[i]) ? (age[i] == AW'(STARVE_LIMIT) ? age[i] : age[i] + AW'(1)) : '0;
      end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scenarios plus randomized traffic against a queue-based lane model
module tb_cdb_arbiter;
   import sys_defs::*;
   localparam int W = 7;
   localparam int L = 2;
   localparam int SL = 4;
   localparam logic [6:0] FIX = 7'b1110000;
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;
   cdb_arbiter_if bus();
   cdb_arbiter #(.STARVE_LIMIT(SL)) dut (.clock(clock), .reset(reset), .bus(bus.master));
   int tests = 0;
   int fails = 0;
   int m_rr;
   int m_age [W];
   bit m_ovf;
   logic [6:0] cur;
   int exp_q [$];
   int exp_last;
   logic [L-1:0][W-1:0] exp_bus;
   logic [W-1:0] exp_gnt;
   int exp_used;
   bit exp_starve;

   function automatic void model_eval(input logic [6:0] r);
      int c [$];
      int idx;
      exp_q.delete();
      exp_last = -1;
      for (int i = 0; i < W; i++) if (FIX[i] && r[i]) exp_q.push_back(i);
      for (int i = 0; i < W; i++) if (!FIX[i] && r[i] && m_age[i] >= SL) exp_q.push_back(i);
      for (int s = 0; s < W; s++) begin
         idx = (m_rr + s) % W;
         if (!FIX[idx] && r[idx] && m_age[idx] < SL) c.push_back(idx);
      end
      foreach (c[k]) if (exp_q.size() < L) begin
         exp_q.push_back(c[k]);
         exp_last = c[k];
      end
      while (exp_q.size() > L) void'(exp_q.pop_back());
      exp_bus = '0;
      exp_gnt = '0;
      foreach (exp_q[k]) begin
         exp_bus[k][exp_q[k]] = 1'b1;
         exp_gnt[exp_q[k]] = 1'b1;
      end
      exp_used = exp_q.size();
      exp_starve = 0;
      for (int i = 0; i < W; i++) if (!FIX[i] && m_age[i] >= SL) exp_starve = 1;
      if (reset) begin
         exp_bus = '0;
         exp_gnt = '0;
         exp_used = 0;
         exp_starve = 0;
      end
   endfunction

   function automatic void model_update(input logic [6:0] r);
      int nf;
      if (reset) begin
         m_rr = 0;
         m_ovf = 0;
         for (int i = 0; i < W; i++) m_age[i] = 0;
         return;
      end
      nf = 0;
      for (int i = 0; i < W; i++) if (FIX[i] && r[i]) nf++;
      if (nf > L) m_ovf = 1;
      for (int i = 0; i < W; i++)
         m_age[i] = (!FIX[i] && r[i] && !exp_gnt[i]) ? (m_age[i] < SL ? m_age[i] + 1 : SL) : 0;
      if (exp_last >= 0) m_rr = (exp_last + 1) % W;
   endfunction

   task automatic drive(input logic [6:0] r);
      cur = r;
      bus.fu_req = r;
      model_eval(r);
      @(negedge clock);
   endtask

   task automatic tick();
      @(posedge clock);
      model_update(cur);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(7'b0);
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(7'b1111111);
      tests++; if (bus.complete_gnt_bus !== '0) begin fails++; $display("FAIL reset_bus got=%b exp=0", bus.complete_gnt_bus); end
      tests++; if (bus.fu_gnt !== '0 || bus.lanes_used !== '0 || bus.starve_active !== 1'b0) begin fails++; $display("FAIL reset_outs gnt=%b used=%0d starve=%b exp=0", bus.fu_gnt, bus.lanes_used, bus.starve_active); end
      tick();
      reset = 1'b0;
      drive(7'b0);
      tests++; if (bus.fixed_overflow !== 1'b0 || dut.rr_ptr !== 3'd0) begin fails++; $display("FAIL reset_state ovf=%b rr=%0d exp=0,0", bus.fixed_overflow, dut.rr_ptr); end
      tests++; if (bus.fu_gnt !== '0 || bus.lanes_used !== '0) begin fails++; $display("FAIL idle gnt=%b used=%0d exp=0", bus.fu_gnt, bus.lanes_used); end
      tick();
   endtask

   task automatic test_fixed_precedence();
      do_reset();
      drive(7'b1110011);
      tests++; if (bus.complete_gnt_bus[0] !== 7'b0010000 || bus.complete_gnt_bus[1] !== 7'b0100000) begin fails++; $display("FAIL fixed_lanes got=%b/%b exp=0010000/0100000", bus.complete_gnt_bus[0], bus.complete_gnt_bus[1]); end
      tests++; if (bus.fixed_overflow !== 1'b0) begin fails++; $display("FAIL fixed_ovf_early got=%b exp=0", bus.fixed_overflow); end
      tick();
      tests++; if (bus.fixed_overflow !== 1'b1) begin fails++; $display("FAIL fixed_ovf_set got=%b exp=1", bus.fixed_overflow); end
      tests++; if (dut.age[0] !== 3'd1 || dut.age[1] !== 3'd1) begin fails++; $display("FAIL fixed_ages got=%0d,%0d exp=1,1", dut.age[0], dut.age[1]); end
      drive(7'b0);
      tick();
      tests++; if (bus.fixed_overflow !== 1'b1) begin fails++; $display("FAIL fixed_ovf_sticky got=%b exp=1", bus.fixed_overflow); end
   endtask

   task automatic test_rotation();
      logic [6:0] eg [3];
      int er [4];
      eg = '{7'b0000011, 7'b0001100, 7'b0000011};
      er = '{0, 2, 4, 2};
      do_reset();
      for (int c = 0; c < 3; c++) begin
         drive(7'b0001111);
         tests++; if (dut.rr_ptr !== 3'(er[c])) begin fails++; $display("FAIL rot_ptr c=%0d got=%0d exp=%0d", c, dut.rr_ptr, er[c]); end
         tests++; if (bus.fu_gnt !== eg[c] || bus.lanes_used !== 2'd2) begin fails++; $display("FAIL rot_gnt c=%0d got=%b used=%0d exp=%b used=2", c, bus.fu_gnt, bus.lanes_used, eg[c]); end
         tick();
      end
      tests++; if (dut.rr_ptr !== 3'(er[3])) begin fails++; $display("FAIL rot_ptr_end got=%0d exp=%0d", dut.rr_ptr, er[3]); end
   endtask

   task automatic test_starvation();
      do_reset();
      for (int c = 0; c < 5; c++) begin
         drive(7'b0110100);
         tests++; if (bus.fu_gnt !== 7'b0110000) begin fails++; $display("FAIL starve_gnt c=%0d got=%b exp=0110000", c, bus.fu_gnt); end
         tests++; if (bus.starve_active !== (c == 4)) begin fails++; $display("FAIL starve_active c=%0d got=%b exp=%b", c, bus.starve_active, c == 4); end
         tick();
      end
      tests++; if (bus.fixed_overflow !== 1'b0 || dut.age[2] !== 3'd4) begin fails++; $display("FAIL starve_state ovf=%b age2=%0d exp=0,4", bus.fixed_overflow, dut.age[2]); end
      drive(7'b0000100);
      tests++; if (bus.complete_gnt_bus[0] !== 7'b0000100 || bus.lanes_used !== 2'd1) begin fails++; $display("FAIL starve_release got=%b used=%0d exp=0000100 used=1", bus.complete_gnt_bus[0], bus.lanes_used); end
      tick();
      tests++; if (dut.age[2] !== 3'd0) begin fails++; $display("FAIL starve_clear got=%0d exp=0", dut.age[2]); end
   endtask

   task automatic test_peer_starvation();
      do_reset();
      drive(7'b0000011);
      tick();
      drive(7'b0000111);
      tests++; if (bus.complete_gnt_bus[0] !== 7'b0000100 || bus.complete_gnt_bus[1] !== 7'b0000001) begin fails++; $display("FAIL peer_lanes got=%b/%b exp=0000100/0000001", bus.complete_gnt_bus[0], bus.complete_gnt_bus[1]); end
      tick();
      tests++; if (dut.age[1] !== 3'd1) begin fails++; $display("FAIL peer_age1 got=%0d exp=1", dut.age[1]); end
      drive(7'b0000111);
      tests++; if (bus.fu_gnt !== 7'b0000110) begin fails++; $display("FAIL peer_next got=%b exp=0000110", bus.fu_gnt); end
      tick();
   endtask

   task automatic test_withdrawal();
      do_reset();
      for (int c = 0; c < 4; c++) begin
         drive(c < 3 ? 7'b0111000 : 7'b0110000);
         tests++; if (bus.fu_gnt[3] !== 1'b0) begin fails++; $display("FAIL wd_gnt c=%0d got=%b exp=0", c, bus.fu_gnt[3]); end
         if (c == 3) begin
            tests++; if (dut.age[3] !== 3'd3) begin fails++; $display("FAIL wd_age3 got=%0d exp=3", dut.age[3]); end
         end
         tick();
      end
      tests++; if (dut.age[3] !== 3'd0) begin fails++; $display("FAIL wd_clear got=%0d exp=0", dut.age[3]); end
   endtask

   task automatic test_reset_mid_run();
      do_reset();
      drive(7'b0001111);
      tick();
      drive(7'b0001111);
      tick();
      tests++; if (dut.rr_ptr !== 3'd4 || dut.age[0] !== 3'd1) begin fails++; $display("FAIL mid_pre rr=%0d age0=%0d exp=4,1", dut.rr_ptr, dut.age[0]); end
      reset = 1'b1;
      drive(7'b0001111);
      tests++; if (bus.complete_gnt_bus !== '0 || bus.fu_gnt !== '0 || bus.lanes_used !== '0 || bus.starve_active !== 1'b0) begin fails++; $display("FAIL mid_outs bus=%b used=%0d exp=0", bus.complete_gnt_bus, bus.lanes_used); end
      tick();
      reset = 1'b0;
      drive(7'b0000011);
      tests++; if (dut.rr_ptr !== 3'd0 || dut.age[0] !== 3'd0) begin fails++; $display("FAIL mid_state rr=%0d age0=%0d exp=0,0", dut.rr_ptr, dut.age[0]); end
      tests++; if (bus.complete_gnt_bus[0] !== 7'b0000001 || bus.complete_gnt_bus[1] !== 7'b0000010) begin fails++; $display("FAIL mid_grant got=%b/%b exp=0000001/0000010", bus.complete_gnt_bus[0], bus.complete_gnt_bus[1]); end
      tick();
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         reset = ($urandom_range(0, 49) == 0);
         drive(7'($urandom));
         tests++; if (bus.complete_gnt_bus !== exp_bus) begin fails++; $display("FAIL rand_bus c=%0d req=%b got=%b exp=%b", c, cur, bus.complete_gnt_bus, exp_bus); end
         tests++; if (bus.fu_gnt !== exp_gnt || bus.lanes_used !== 2'(exp_used)) begin fails++; $display("FAIL rand_gnt c=%0d got=%b/%0d exp=%b/%0d", c, bus.fu_gnt, bus.lanes_used, exp_gnt, exp_used); end
         tests++; if (bus.starve_active !== exp_starve || bus.fixed_overflow !== m_ovf) begin fails++; $display("FAIL rand_flags c=%0d got=%b%b exp=%b%b", c, bus.starve_active, bus.fixed_overflow, exp_starve, m_ovf); end
         tests++; if (dut.rr_ptr !== 3'(m_rr)) begin fails++; $display("FAIL rand_ptr c=%0d got=%0d exp=%0d", c, dut.rr_ptr, m_rr); end
         tick();
      end
      reset = 1'b0;
   endtask

   initial begin
      bus.fu_req = '0;
      cur = '0;
      m_rr = 0;
      m_ovf = 0;
      for (int i = 0; i < W; i++) m_age[i] = 0;
      test_reset();
      test_fixed_precedence();
      test_rotation();
      test_starvation();
      test_peer_starvation();
      test_withdrawal();
      test_reset_mid_run();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
